// File: rtl/vga_timing_pkg.sv
// Shared constants and types for the VGA raster timing generator.
// Defaults describe 640x480 at 60 Hz (800 x 525 pixel periods).
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Largest total that still fits the 10-bit coordinate type.
  localparam int MAX_TOTAL = 1024;

  function automatic int timing_total(input int active, input int fp,
                                      input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int DEF_H_TOTAL = timing_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int DEF_V_TOTAL = timing_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

  typedef logic [9:0] coord_t;

endpackage

// File: rtl/pix_tick_div.sv
// Divide-by-4 pixel strobe, used by vga_timing_gen only when
// VGA_TIMING_INTERNAL_DIV_EN is defined. tick is high while the count is 3.
module pix_tick_div (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  logic [1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt <= 2'd0;
    else        cnt <= cnt + 2'd1;
  end

  assign tick = (cnt == 2'd3);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: sync, active-video, coordinates and line/frame
// markers. Define VGA_TIMING_INTERNAL_DIV_EN to use an internal /4 strobe.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_en,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_total_check
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end

  localparam coord_t      H_LAST = coord_t'(H_TOTAL - 1);
  localparam coord_t      V_LAST = coord_t'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS  = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_VIS  = 11'(V_ACTIVE);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic tick;

`ifdef VGA_TIMING_INTERNAL_DIV_EN
  logic unused_pix_en;
  assign unused_pix_en = pix_en;

  pix_tick_div u_div (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );
`else
  assign tick = pix_en;
`endif

  coord_t      h_cnt, v_cnt, h_next, v_next;
  logic        h_wrap, v_wrap, hs_on, vs_on, vid_on;
  logic [10:0] h_next_w, v_next_w;

  // Syncs and video_on decode the next-state counts so they land with x/y.
  always_comb begin
    // NOTE: every variable gets a value on every path; a missed branch would infer a latch.
    h_wrap = (h_cnt == H_LAST);
    v_wrap = h_wrap && (v_cnt == V_LAST);
    h_next = h_wrap ? coord_t'(0) : h_cnt + coord_t'(1);
    v_next = v_cnt;
    if (h_wrap) v_next = v_wrap ? coord_t'(0) : v_cnt + coord_t'(1);

    h_next_w = {1'b0, h_next};
    v_next_w = {1'b0, v_next};
    hs_on    = (h_next_w >= HS_BEG) && (h_next_w < HS_END);
    vs_on    = (v_next_w >= VS_BEG) && (v_next_w < VS_END);
    vid_on   = (h_next_w < H_VIS) && (v_next_w < V_VIS);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      video_on    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge state together.
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (tick) begin
        h_cnt       <= h_next;
        v_cnt       <= v_next;
        hsync       <= hs_on ? SYNC_POL : ~SYNC_POL;
        vsync       <= vs_on ? SYNC_POL : ~SYNC_POL;
        video_on    <= vid_on;
        line_start  <= h_wrap;
        frame_start <= v_wrap;
      end
    end
  end

  assign x = h_cnt;
  assign y = v_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: a default 640x480 instance and a small
// active-high-sync instance share stimulus and are checked every cycle.
module tb_vga_timing_gen;

  localparam int CLK_P = 10;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       von;
    logic       ls;
    logic       fs;
  } obs_t;

  typedef struct {
    int ha, hf, hw, hb;
    int va, vf, vw, vb;
    bit pol;
  } tim_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       pix_en;

  logic       hs_d, vs_d, von_d, ls_d, fs_d;
  logic [9:0] x_d, y_d;
  logic       hs_s, vs_s, von_s, ls_s, fs_s;
  logic [9:0] x_s, y_s;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_d = 0;
  int   n_s = 0;
  int   exp_ls = 0, exp_fs = 0, act_ls = 0, act_fs = 0;
  tim_t td, ts;
  obs_t q_d[$];
  obs_t q_s[$];

  always #(CLK_P / 2) clk = ~clk;

  vga_timing_gen dut_d (
    .clk(clk), .reset(reset), .pix_en(pix_en),
    .hsync(hs_d), .vsync(vs_d), .video_on(von_d),
    .x(x_d), .y(y_d), .line_start(ls_d), .frame_start(fs_d)
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(5),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .SYNC_POL(1'b1)
  ) dut_s (
    .clk(clk), .reset(reset), .pix_en(pix_en),
    .hsync(hs_s), .vsync(vs_s), .video_on(von_s),
    .x(x_s), .y(y_s), .line_start(ls_s), .frame_start(fs_s)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Expected outputs after n strobes since reset, from raster arithmetic.
  function automatic obs_t model(input tim_t t, input int n, input bit strobed);
    int   ht, vt, xx, yy;
    obs_t o;
    ht = t.ha + t.hf + t.hw + t.hb;
    vt = t.va + t.vf + t.vw + t.vb;
    xx = n % ht;
    yy = (n / ht) % vt;
    o.x = 10'(xx);
    o.y = 10'(yy);
    if (n == 0) begin
      o.hs = ~t.pol; o.vs = ~t.pol; o.von = 1'b0; o.ls = 1'b0; o.fs = 1'b0;
    end else begin
      o.hs  = (xx >= t.ha + t.hf && xx < t.ha + t.hf + t.hw) ? t.pol : ~t.pol;
      o.vs  = (yy >= t.va + t.vf && yy < t.va + t.vf + t.vw) ? t.pol : ~t.pol;
      o.von = (xx < t.ha) && (yy < t.va);
      o.ls  = strobed && (xx == 0);
      o.fs  = strobed && (xx == 0) && (yy == 0);
    end
    return o;
  endfunction

  task automatic advance(input bit strobed);
    obs_t es;
    if (strobed) begin
      n_d++;
      n_s++;
    end
    es = model(ts, n_s, strobed);
    if (es.ls) exp_ls++;
    if (es.fs) exp_fs++;
    q_d.push_back(model(td, n_d, strobed));
    q_s.push_back(es);
  endtask

  task automatic step(input bit en);
    pix_en = en;
    @(posedge clk);
    #1;
    advance(en && reset);
  endtask

  task automatic compare(input string tag, input obs_t a, input obs_t e);
    check({tag, ".x"},           32'(a.x),   32'(e.x));
    check({tag, ".y"},           32'(a.y),   32'(e.y));
    check({tag, ".hsync"},       32'(a.hs),  32'(e.hs));
    check({tag, ".vsync"},       32'(a.vs),  32'(e.vs));
    check({tag, ".video_on"},    32'(a.von), 32'(e.von));
    check({tag, ".line_start"},  32'(a.ls),  32'(e.ls));
    check({tag, ".frame_start"}, 32'(a.fs),  32'(e.fs));
  endtask

  // Monitor: one expected entry per clk, compared on the falling edge.
  initial begin
    obs_t e;
    forever begin
      @(negedge clk);
      if (q_d.size() > 0) begin
        e = q_d.pop_front();
        compare("dflt", {x_d, y_d, hs_d, vs_d, von_d, ls_d, fs_d}, e);
      end
      if (q_s.size() > 0) begin
        e = q_s.pop_front();
        compare("small", {x_s, y_s, hs_s, vs_s, von_s, ls_s, fs_s}, e);
        if (ls_s) act_ls++;
        if (fs_s) act_fs++;
      end
    end
  end

  initial begin
    #(CLK_P * 50000);
    $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t e_d, e_s;
    td = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0};
    ts = '{16, 4, 6, 5, 12, 2, 2, 3, 1'b1};
    reset  = 1'b0;
    pix_en = 1'b0;
    repeat (3) step(1'b1);
    reset = 1'b1;

    // Divider-like cadence: one strobe every fourth clk.
    for (int i = 0; i < 650; i++) begin
      step(1'b0); step(1'b0); step(1'b0); step(1'b1);
    end
    for (int i = 0; i < 2000; i++) step(1'($urandom_range(0, 1)));
    repeat (100) step(1'b0);
    for (int i = 0; i < 1800; i++) step(1'b1);

    // Park the default instance inside hsync, then reset asynchronously.
    for (int i = 0; i < 2000 && (n_d % 800) != 700; i++) step(1'b1);
    check("reach_x700", 32'(n_d % 800), 32'd700);
    check("hsync_before_rst", 32'(hs_d), 32'd0);
    #1 reset = 1'b0;
    #1;
    n_d = 0;
    n_s = 0;
    e_d = model(td, 0, 1'b0);
    e_s = model(ts, 0, 1'b0);
    void'(q_d.pop_back());
    void'(q_s.pop_back());
    q_d.push_back(e_d);
    q_s.push_back(e_s);
    check("rst_hsync", 32'(hs_d), 32'(e_d.hs));
    check("rst_x", 32'(x_d), 32'(e_d.x));
    check("rst_y", 32'(y_d), 32'(e_d.y));
    check("rst_video_on", 32'(von_d), 32'(e_d.von));
    check("rst_small_hsync", 32'(hs_s), 32'(e_s.hs));

    repeat (3) step(1'b1);
    reset = 1'b1;
    step(1'b1);
    check("post_rst_x", 32'(x_d), 32'd1);
    check("post_rst_video_on", 32'(von_d), 32'd1);
    for (int i = 0; i < 300; i++) step(1'($urandom_range(0, 1)));
    step(1'b0);

    @(negedge clk);
    #1;
    check("queue_d_drained", 32'(q_d.size()), 32'd0);
    check("queue_s_drained", 32'(q_s.size()), 32'd0);
    check("line_start_count", 32'(act_ls), 32'(exp_ls));
    check("frame_start_count", 32'(act_fs), 32'(exp_fs));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator that consumes the one-cycle pixel strobe from the 25 MHz pixel-rate divider and produces VGA horizontal/vertical sync, active-video flag, pixel coordinates and line/frame markers. It sits between the pixel-rate divider and the sprite/pixel pipeline. Default timing is 640x480 at 60 Hz: 800 pixel periods per line and 525 lines per frame.

## Interface

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch, in pixels
- H_SYNC, 96, hsync pulse width, in pixels
- H_BP, 48, horizontal back porch, in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch, in lines
- V_SYNC, 2, vsync pulse width, in lines
- V_BP, 33, vertical back porch, in lines
- SYNC_POL, 0, asserted sync level; 0 means active-low

Ports:
- clk  in  1  system clock (100 MHz)
- reset  in  1  asynchronous, active-low reset
- pix_en  in  1  pixel strobe from the divider; one clk cycle high per pixel period
- hsync  out  1  horizontal sync, at the SYNC_POL level when asserted
- vsync  out  1  vertical sync, at the SYNC_POL level when asserted
- video_on  out  1  high while (x,y) is inside the visible area
- x  out  10  current horizontal count, 0..H_TOTAL-1
- y  out  10  current vertical count, 0..V_TOTAL-1
- line_start  out  1  one-clk pulse when x wraps to 0
- frame_start  out  1  one-clk pulse when (x,y) wraps to (0,0)

## Operation

- Totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
  - Both totals must be ≤1024; this is checked by an elaboration-time assertion.
- Counters h_cnt and v_cnt advance only on clk edges where pix_en=1.
  - When pix_en=0, all outputs hold, and the pulse outputs are 0.
- Horizontal: h_cnt counts 0..H_TOTAL-1, then wraps to 0.
- Vertical: v_cnt increments only on the horizontal wrap, counts 0..V_TOTAL-1, then wraps to 0.
- hsync is asserted when H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC. Default range: 656..751.
- vsync is asserted when V_ACTIVE+V_FP ≤ v_cnt < V_ACTIVE+V_FP+V_SYNC. Default range: 490..491.
- video_on = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- Coordinates: x = h_cnt and y = v_cnt, unsigned and zero-padded to 10 bits.
- pix_en high on consecutive cycles is legal; the counters then advance every clk.

## Timing

- Every output is driven directly from a flop, so outputs are glitch-free.
- hsync, vsync and video_on are decoded from next-state counter values. They therefore change on the same clk edge as x and y and stay aligned with them.
  - Latency from the pix_en edge to the updated outputs: 0 extra cycles.
- line_start is high for exactly the one clk following the edge that wraps h_cnt to 0.
- frame_start is high for exactly the one clk following the edge that wraps both counters to 0. line_start is also high in that cycle.
- Reset values, applied immediately on reset low:
  - x=0, y=0
  - hsync=vsync=~SYNC_POL (inactive)
  - video_on=0
  - line_start=frame_start=0
- After reset release:
  - The first pix_en edge advances the counters to (1,0) and decodes video_on=1.
  - No frame_start pulse is issued until the first natural wrap.
- Reset asserted mid-frame: the frame is abandoned, and the outputs take their reset values in the same cycle.

## Configuration

- Macro: VGA_TIMING_INTERNAL_DIV_EN.
- Defined:
  - The pix_en port is ignored.
  - An internal divider instance generates the strobe, high on every fourth clk; the first strobe comes on the 4th clk after reset release.
- Undefined: the pix_en port drives the counters directly, and no divider logic is synthesized.

## Structure

- Shared package vga_timing_pkg holds:
  - the default 640x480 timing constants;
  - the derived H_TOTAL/V_TOTAL localparam formulas;
  - the 10-bit coordinate type.
- Sub-module pix_tick_div is instantiated only under VGA_TIMING_INTERNAL_DIV_EN.
  - Ports: clk, reset, tick; 2-bit counter; tick high when the count is 3.

## Test plan

- Reset low, then pix_en pulses every 4th clk for one full frame:
  - exactly 420000 strobes return (x,y) to (0,0);
  - frame_start pulses once, and line_start pulses 525 times.
- Horizontal sync and active video:
  - hsync low for exactly 96 strobes, starting at x=656;
  - video_on falls at x=640 and rises at x=0, for every y<480.
- vsync low exactly while y is 490 or 491; video_on stays 0 for all y ≥ 480.
- pix_en held low for 100 clk mid-line: x, y and the syncs are frozen, and no pulses are issued.
- Reset asserted at (x,y)=(700,300), inside hsync:
  - in the same cycle, hsync=1, x=0, y=0 and video_on=0;
  - after release, the first strobe gives x=1.
- VGA_TIMING_INTERNAL_DIV_EN defined, pix_en tied to 0: x increments every 4 clk, and a full line takes 3200 clk.
